// File: rtl/router_fifo_if.sv
// Byte-stream handshake between the router register stage / FSM and the output FIFO.
interface router_fifo_if;
   logic       soft_reset;
   logic       write_enb;
   logic       read_enb;
   logic       lfd_state;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
   logic       pkt_active;

   modport master (
      output soft_reset, write_enb, read_enb, lfd_state, data_in,
      input  data_out, full, empty, pkt_active
   );

   modport slave (
      input  soft_reset, write_enb, read_enb, lfd_state, data_in,
      output data_out, full, empty, pkt_active
   );
endinterface

// File: rtl/router_fifo.sv
// Router output FIFO: 9-bit entries {header flag, byte}, registered read data and a
// per-packet byte counter that tracks how many bytes of the current packet remain.
module router_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input logic         clock,
   input logic         resetn,
   router_fifo_if.slave bus
);

   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = 7;

   logic [8:0]    mem [DEPTH];

   logic [1:0]    rst_sync_q;
   logic          rst_int_n;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    data_out_q, data_out_d;
   logic          pkt_active_q, pkt_active_d;

   logic          full_c, empty_c, do_wr, do_rd;
   logic [8:0]    rd_entry;

   // Assert immediately, release two edges after resetn rises.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) rst_sync_q <= 2'b00;
      else         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   assign empty_c  = (wr_ptr_q == rd_ptr_q);
   assign full_c   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_wr    = bus.write_enb && !full_c && !bus.soft_reset;
   assign do_rd    = bus.read_enb && !empty_c && !bus.soft_reset;
   assign rd_entry = mem[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      data_out_d = data_out_q;
      if (bus.soft_reset) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         cnt_d      = '0;
         data_out_d = '0;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_rd) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            data_out_d = rd_entry[7:0];
            // Header carries payload length in [7:2]; +1 accounts for the parity byte.
            if (rd_entry[8])          cnt_d = CW'(rd_entry[7:2]) + CW'(1);
            else if (cnt_q != '0)     cnt_d = cnt_q - CW'(1);
         end
      end
      pkt_active_d = (cnt_d != '0);
   end

   always_ff @(posedge clock or negedge rst_int_n) begin
      if (!rst_int_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         data_out_q   <= '0;
         pkt_active_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         data_out_q   <= data_out_d;
         pkt_active_q <= pkt_active_d;
      end
   end

   // Storage is never cleared; pointer reset makes old entries unreachable.
   always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
   end

   assign bus.data_out   = data_out_q;
   assign bus.full       = full_c;
   assign bus.empty      = empty_c;
   assign bus.pkt_active = pkt_active_q;

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios plus random traffic against a queue model.
module tb_router_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   logic clk;
   logic rst_n;

   router_fifo_if bus ();

   router_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clock  (clk),
      .resetn (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [8:0] q[$];
   logic [7:0] m_dout;
   int         m_cnt;
   int         checks;
   int         passes;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".data_out"},   32'(bus.data_out),   32'(m_dout));
      chk({tag, ".empty"},      32'(bus.empty),      32'(q.size() == 0));
      chk({tag, ".full"},       32'(bus.full),       32'(q.size() == DEPTH));
      chk({tag, ".pkt_active"}, 32'(bus.pkt_active), 32'(m_cnt != 0));
   endtask

   // One clock: drive, advance, update model from pre-edge occupancy, then compare.
   task automatic cyc(input logic we, input logic re, input logic lfd,
                      input logic [7:0] din, input logic sr, input string tag);
      bit         can_wr;
      bit         can_rd;
      logic [8:0] e;
      bus.write_enb  = we;
      bus.read_enb   = re;
      bus.lfd_state  = lfd;
      bus.data_in    = din;
      bus.soft_reset = sr;
      can_wr = we && !sr && (q.size() < DEPTH);
      can_rd = re && !sr && (q.size() > 0);
      @(posedge clk);
      #1;
      if (sr) begin
         q.delete();
         m_dout = 8'h00;
         m_cnt  = 0;
      end else begin
         if (can_rd) begin
            e      = q.pop_front();
            m_dout = e[7:0];
            if (e[8])           m_cnt = int'(e[7:2]) + 1;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
         end
         if (can_wr) q.push_back({lfd, din});
      end
      chk_all(tag);
   endtask

   task automatic wr(input logic lfd, input logic [7:0] din, input string tag);
      cyc(1'b1, 1'b0, lfd, din, 1'b0, tag);
   endtask

   task automatic rd(input string tag);
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, tag);
   endtask

   task automatic idle(input string tag);
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, tag);
   endtask

   initial begin
      logic [7:0] pkt [5];
      logic [7:0] b;
      checks = 0;
      passes = 0;
      m_dout = 8'h00;
      m_cnt  = 0;
      clk    = 1'b0;
      rst_n  = 1'b0;
      bus.soft_reset = 1'b0;
      bus.write_enb  = 1'b0;
      bus.read_enb   = 1'b0;
      bus.lfd_state  = 1'b0;
      bus.data_in    = 8'h00;

      #12;
      chk_all("reset");
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) idle("release");

      // Header + payload packet
      pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h1F;
      for (int i = 0; i < 5; i++) wr(i == 0, pkt[i], "pkt_wr");
      for (int i = 0; i < 5; i++) begin
         rd("pkt_rd");
         chk("pkt_rd_byte", 32'(bus.data_out), 32'(pkt[i]));
         chk("pkt_active_seq", 32'(bus.pkt_active), 32'(i < 4));
      end
      chk("pkt_empty", 32'(bus.empty), 32'd1);

      // Fill to full, drop the overflow write, drain in order
      for (int i = 0; i < 16; i++) wr(1'b0, 8'(i), "fill_wr");
      chk("fill_full", 32'(bus.full), 32'd1);
      wr(1'b0, 8'hAA, "fill_drop");
      for (int i = 0; i < 16; i++) begin
         rd("fill_rd");
         chk("fill_rd_byte", 32'(bus.data_out), 32'(i));
      end
      chk("fill_empty", 32'(bus.empty), 32'd1);

      // Simultaneous read+write at full and at empty
      for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h40 + i), "sim_fill");
      cyc(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0, "sim_full");
      chk("sim_full_clr", 32'(bus.full), 32'd0);
      chk("sim_full_rd", 32'(bus.data_out), 32'h40);
      for (int i = 0; i < 15; i++) rd("sim_drain");
      b = bus.data_out;
      cyc(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, "sim_empty");
      chk("sim_empty_wr", 32'(bus.empty), 32'd0);
      chk("sim_empty_hold", 32'(bus.data_out), 32'(b));
      rd("sim_last");
      chk("sim_last_byte", 32'(bus.data_out), 32'hC3);

      // Pointer wrap with interleaved pairs
      for (int i = 0; i < 40; i++) begin
         wr(1'b0, 8'(8'h80 + i), "wrap_wr");
         rd("wrap_rd");
         chk("wrap_byte", 32'(bus.data_out), 32'(8'(8'h80 + i)));
         chk("wrap_nofull", 32'(bus.full), 32'd0);
      end

      // soft_reset beats a concurrent read
      wr(1'b1, 8'h08, "sr_hdr");
      for (int i = 0; i < 5; i++) wr(1'b0, 8'(8'h60 + i), "sr_wr");
      rd("sr_hdr_rd");
      chk("sr_pkt_on", 32'(bus.pkt_active), 32'd1);
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "sr_pulse");
      chk("sr_empty", 32'(bus.empty), 32'd1);
      chk("sr_dout", 32'(bus.data_out), 32'h00);
      chk("sr_cnt", 32'(bus.pkt_active), 32'd0);
      rd("sr_noread");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 5) == 0), 8'($urandom),
             1'($urandom_range(0, 63) == 0), "rand");
      end
      for (int i = 0; i < DEPTH; i++) rd("rand_drain");

      // Async reset mid-packet
      wr(1'b1, 8'h0D, "ar_hdr");
      wr(1'b0, 8'h11, "ar_p1");
      wr(1'b0, 8'h22, "ar_p2");
      rd("ar_rd");
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      m_dout = 8'h00;
      m_cnt  = 0;
      chk_all("async_rst");
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) idle("ar_release");
      wr(1'b0, 8'h55, "ar_wr55");
      rd("ar_rd55");
      chk("ar_byte55", 32'(bus.data_out), 32'h55);
      chk("ar_empty", 32'(bus.empty), 32'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
